// File: rtl/icache_pkg.sv
// Shared types and default geometry for the instruction cache.
package icache_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned DEF_INDEX_W  = 6;
  localparam int unsigned DEF_OFFSET_W = 4;

  typedef enum logic [1:0] {
    ICACHE_IDLE = 2'd0,
    ICACHE_FILL = 2'd1,
    ICACHE_RESP = 2'd2,
    ICACHE_COOL = 2'd3
  } icache_state_t;

endpackage

// File: rtl/icache_store.sv
// Tag, valid and data arrays of the direct-mapped instruction cache.
// One combinational read port, one word write port and a tag/valid commit strobe.
module icache_store
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_W  = DEF_INDEX_W,
  parameter int unsigned OFFSET_W = DEF_OFFSET_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [INDEX_W-1:0]              i_rd_index,
  input  logic [OFFSET_W-3:0]             i_rd_word,
  input  logic [XLEN-INDEX_W-OFFSET_W-1:0] i_rd_tag,
  output logic                            o_rd_hit_c,
  output logic [XLEN-1:0]                 o_rd_data_c,
  input  logic                            i_wr_en,
  input  logic [INDEX_W-1:0]              i_wr_index,
  input  logic [OFFSET_W-3:0]             i_wr_word,
  input  logic [XLEN-1:0]                 i_wr_data,
  input  logic                            i_commit,
  input  logic [XLEN-INDEX_W-OFFSET_W-1:0] i_commit_tag
);

  localparam int unsigned TAG_W  = XLEN - INDEX_W - OFFSET_W;
  localparam int unsigned WORD_W = OFFSET_W - 2;
  localparam int unsigned LINES  = 1 << INDEX_W;
  localparam int unsigned WORDS  = 1 << WORD_W;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [XLEN-1:0]  r_data [LINES][WORDS];

  // Valid bits: cleared only by reset, set when a completed line is committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_commit) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Data words are written beat by beat; the tag lands with the final beat.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_index][i_wr_word] <= i_wr_data;
    end
    if (i_commit) begin
      r_tag[i_wr_index] <= i_commit_tag;
    end
  end

  assign o_rd_hit_c  = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
  assign o_rd_data_c = r_data[i_rd_index][i_rd_word];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: serves one word per request,
// fills a whole line from memory on a miss and drops rolled-back responses.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_W  = DEF_INDEX_W,
  parameter int unsigned OFFSET_W = DEF_OFFSET_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            fetch_req,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            fetch_stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_out,
  input  logic            rollback,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned TAG_W  = XLEN - INDEX_W - OFFSET_W;
  localparam int unsigned WORD_W = OFFSET_W - 2;
  localparam int unsigned WORDS  = 1 << WORD_W;

  icache_state_t     r_state;
  logic [XLEN-1:0]   r_pc;
  logic [WORD_W-1:0] r_cnt;
  logic              r_kill;

  logic [XLEN-1:0]    w_rd_pc;
  logic [TAG_W-1:0]   w_rd_tag;
  logic [INDEX_W-1:0] w_rd_index;
  logic [WORD_W-1:0]  w_rd_word;
  logic               w_hit;
  logic [XLEN-1:0]    w_rd_data;
  logic               w_fill_beat;
  logic               w_last_beat;
  logic [XLEN-1:0]    w_fill_word;
  logic               w_unused_lsb;

  // Lookup uses the live pc while idle, the latched pc while filling.
  assign w_rd_pc    = (r_state == ICACHE_IDLE) ? fetch_pc : r_pc;
  assign w_rd_tag   = w_rd_pc[XLEN-1:INDEX_W+OFFSET_W];
  assign w_rd_index = w_rd_pc[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign w_rd_word  = w_rd_pc[OFFSET_W-1:2];
  assign w_unused_lsb = ^w_rd_pc[1:0];

  assign w_fill_beat = !rst && rdy && (r_state == ICACHE_FILL) && mem_rvalid;
  assign w_last_beat = w_fill_beat && (r_cnt == WORD_W'(WORDS - 1));
  // The requested word may be arriving on this very beat, before it is stored.
  assign w_fill_word = (r_pc[OFFSET_W-1:2] == r_cnt) ? mem_rdata : w_rd_data;

  icache_store #(
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W)
  ) u_store (
    .clk          (clk),
    .rst          (rst),
    .i_rd_index   (w_rd_index),
    .i_rd_word    (w_rd_word),
    .i_rd_tag     (w_rd_tag),
    .o_rd_hit_c   (w_hit),
    .o_rd_data_c  (w_rd_data),
    .i_wr_en      (w_fill_beat),
    .i_wr_index   (r_pc[INDEX_W+OFFSET_W-1:OFFSET_W]),
    .i_wr_word    (r_cnt),
    .i_wr_data    (mem_rdata),
    .i_commit     (w_last_beat),
    .i_commit_tag (r_pc[XLEN-1:INDEX_W+OFFSET_W])
  );

  // Request/fill/response FSM with registered fetcher and memory outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ICACHE_IDLE;
      r_pc        <= '0;
      r_cnt       <= '0;
      r_kill      <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else if (rdy) begin
      case (r_state)
        ICACHE_IDLE: begin
          if (fetch_req && !rollback) begin
            r_pc <= fetch_pc;
            if (w_hit) begin
              instr_out   <= w_rd_data;
              instr_valid <= 1'b1;
              r_state     <= ICACHE_RESP;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= {fetch_pc[XLEN-1:OFFSET_W], OFFSET_W'(0)};
              r_cnt    <= '0;
              r_state  <= ICACHE_FILL;
            end
          end
        end
        ICACHE_FILL: begin
          if (rollback) begin
            r_kill <= 1'b1;
          end
          if (mem_rvalid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == WORD_W'(WORDS - 1)) begin
              mem_req <= 1'b0;
              if (r_kill || rollback) begin
                r_kill  <= 1'b0;
                r_state <= ICACHE_COOL;
              end else begin
                instr_valid <= 1'b1;
                instr_out   <= w_fill_word;
                r_state     <= ICACHE_RESP;
              end
            end
          end
        end
        ICACHE_RESP: begin
          if (rollback || !fetch_stall) begin
            instr_valid <= 1'b0;
            r_state     <= ICACHE_COOL;
          end
        end
        ICACHE_COOL: begin
          r_state <= ICACHE_IDLE;
        end
        default: begin
          r_state <= ICACHE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed plan cases plus randomized traffic
// against a line-residency model and a sparse memory image.
module tb_icache;

  localparam int unsigned IDXW       = 6;
  localparam int unsigned OFFW       = 4;
  localparam int unsigned LINES      = 1 << IDXW;
  localparam int unsigned WORDS      = 1 << (OFFW - 2);
  localparam int unsigned LINE_BYTES = 1 << OFFW;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_stall;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic        rollback;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  icache #(.INDEX_W(IDXW), .OFFSET_W(OFFW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_stall (fetch_stall),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .rollback    (rollback),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q [$];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] res_line [LINES];
  bit          res_valid [LINES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    return mem_model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each new response pops one expected word; held responses must stay stable.
  initial begin
    bit          prev;
    logic [31:0] held;
    prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else if (instr_valid) begin
        if (!prev) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: got %h expected no response at %0t", instr_out, $time);
            held = instr_out;
          end else begin
            held = exp_q.pop_front();
            check("resp_data", instr_out, held);
          end
        end else begin
          check("resp_hold", instr_out, held);
        end
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Consume (or roll back) a presented response, then let COOL pass.
  task automatic finish_resp(input int stall, input bit rb);
    for (int s = 0; s < stall; s++) begin
      fetch_stall = 1'b1;
      @(posedge clk); #1;
      check("stall_hold_valid", instr_valid, 1);
    end
    fetch_stall = rb ? 1'($urandom_range(0, 1)) : 1'b0;
    rollback    = rb;
    @(posedge clk); #1;
    rollback    = 1'b0;
    fetch_stall = 1'b0;
    check("resp_drop", instr_valid, 0);
    @(posedge clk); #1;
  endtask

  // One fetch from IDLE; acts as the memory controller on a miss.
  task automatic run_fetch(input logic [31:0] pc, input int stall, input int rb_fill,
                           input bit rb_resp, input int freeze_beat, input int rst_beat);
    logic [31:0] line;
    int          idx;
    bit          hit;
    bit          respond;
    line    = pc & ~32'(LINE_BYTES - 1);
    idx     = int'((pc >> OFFW) % LINES);
    hit     = res_valid[idx] && (res_line[idx] == line);
    respond = hit || (rb_fill < 0 && rst_beat < 0);
    if (respond) exp_q.push_back(mem_word(pc & ~32'h3));
    fetch_req = 1'b1;
    fetch_pc  = pc;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    if (hit) begin
      check("hit_valid", instr_valid, 1);
      check("hit_no_mem_req", mem_req, 0);
    end else begin
      check("miss_mem_req", mem_req, 1);
      check("miss_mem_addr", mem_addr, line);
      check("miss_no_valid", instr_valid, 0);
      for (int b = 0; b < int'(WORDS); b++) begin
        if (b == rst_beat) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          check("rst_mem_req", mem_req, 0);
          check("rst_valid", instr_valid, 0);
          for (int i = 0; i < int'(LINES); i++) res_valid[i] = 1'b0;
          return;
        end
        if (b == freeze_beat) begin
          rdy        = 1'b0;
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hDEAD_BEEF;
          repeat (5) begin
            @(posedge clk); #1;
            check("freeze_mem_req", mem_req, 1);
            check("freeze_mem_addr", mem_addr, line);
            check("freeze_valid", instr_valid, 0);
          end
          rdy = 1'b1;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(line + 32'(4 * b));
        rollback   = (b == rb_fill);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        rollback   = 1'b0;
        check("fill_mem_req", mem_req, 32'(b < int'(WORDS) - 1));
      end
      res_valid[idx] = 1'b1;
      res_line[idx]  = line;
      check("fill_resp_valid", instr_valid, 32'(respond));
    end
    if (respond) finish_resp(stall, rb_resp);
    else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; fetch_req = 1'b0; fetch_pc = '0; fetch_stall = 1'b0;
    rollback = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < int'(LINES); i++) begin res_valid[i] = 1'b0; res_line[i] = '0; end
    mem_model[32'h0] = 32'h11;
    mem_model[32'h4] = 32'h22;
    mem_model[32'h8] = 32'h33;
    mem_model[32'hC] = 32'h44;

    repeat (3) @(posedge clk);
    #1;
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold miss then hits in the same line.
    run_fetch(32'h4, 0, -1, 0, -1, -1);
    run_fetch(32'hC, 0, -1, 0, -1, -1);

    // Stalled hit, then a request held through COOL is only taken afterwards.
    fetch_req = 1'b1; fetch_pc = 32'h8;
    exp_q.push_back(mem_word(32'h8));
    @(posedge clk); #1;
    fetch_req = 1'b0;
    check("stall_case_valid", instr_valid, 1);
    fetch_stall = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall3_valid", instr_valid, 1);
    end
    fetch_stall = 1'b0;
    fetch_req = 1'b1; fetch_pc = 32'h0;
    exp_q.push_back(mem_word(32'h0));
    @(posedge clk); #1;
    check("consume_drop", instr_valid, 0);
    @(posedge clk); #1;
    check("cool_ignore_valid", instr_valid, 0);
    check("cool_ignore_req", mem_req, 0);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    check("post_cool_hit", instr_valid, 1);
    finish_resp(0, 0);

    // Rollback during fill: line installed, no response; then a hit.
    run_fetch(32'h100, 0, 2, 0, -1, -1);
    run_fetch(32'h104, 0, -1, 0, -1, -1);
    // Rollback on the last beat.
    run_fetch(32'h140, 0, 3, 0, -1, -1);
    run_fetch(32'h148, 1, -1, 0, -1, -1);

    // Rollback in IDLE blocks acceptance.
    fetch_req = 1'b1; fetch_pc = 32'h200; rollback = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0; rollback = 1'b0;
    check("idle_rb_valid", instr_valid, 0);
    check("idle_rb_req", mem_req, 0);

    // Conflict eviction on the same index.
    run_fetch(32'h0, 0, -1, 0, -1, -1);
    run_fetch(32'h400, 0, -1, 0, -1, -1);
    run_fetch(32'h0, 0, -1, 0, -1, -1);

    // Freeze mid-fill, then reset mid-fill.
    run_fetch(32'h20, 0, -1, 0, 2, -1);
    run_fetch(32'h2C, 0, -1, 0, -1, -1);
    run_fetch(32'h30, 0, -1, 0, -1, 2);
    run_fetch(32'h30, 0, -1, 0, -1, -1);

    // Randomized traffic over a small address window.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] pc;
      int          mode;
      int          rbf;
      pc = (32'($urandom_range(0, 2)) << (IDXW + OFFW)) | (32'($urandom_range(0, 7)) << OFFW)
         | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 5));
      rbf  = (mode == 0) ? int'($urandom_range(0, 3)) : -1;
      run_fetch(pc, int'($urandom_range(0, 2)), rbf, mode == 1, -1, -1);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetcher (upstream requester) and the memory controller (line-fill source).
- Serves one 32-bit instruction per request.
- On a miss, fills a whole line word-by-word from the memory controller, then responds.
- Drops responses invalidated by a ROB rollback.

Parameters:
INDEX_W, 6, line-index bits (64 lines)
OFFSET_W, 4, byte-offset bits per line (16-byte lines, 4 words); must be >= 3
(derived) TAG_W = 32-INDEX_W-OFFSET_W; WORDS = 2^(OFFSET_W-2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; 0 = freeze all state
fetch_req  in  1  fetcher requests an instruction (level)
fetch_pc  in  32  request address; bits [1:0] ignored
fetch_stall  in  1  fetcher cannot consume this cycle (lsb|rs|rob full)
instr_valid  out  1  response valid (registered)
instr_out  out  32  instruction word (registered)
rollback  in  1  ROB rollback; kill outstanding response
mem_req  out  1  line-fill request, held high until last beat
mem_addr  out  32  line-aligned fill address (low OFFSET_W bits zero)
mem_rvalid  in  1  one fill beat valid
mem_rdata  in  32  fill word; beats arrive in ascending word order

Behaviour:
- Reset values: instr_valid=0, instr_out=0, mem_req=0, mem_addr=0, state=IDLE, every line valid bit=0, fill counter=0, kill flag=0.
- rdy=0: every register holds, including arrays and the FSM.
- Storage: valid[2^INDEX_W], tag[2^INDEX_W], data[2^INDEX_W][WORDS]; combinational read.
- Address split: tag=pc[31:INDEX_W+OFFSET_W], index=pc[INDEX_W+OFFSET_W-1:OFFSET_W], word=pc[OFFSET_W-1:2].
- The request PC is latched on acceptance.
- FSM states: IDLE, FILL, RESP, COOL.
- IDLE, fetch_req=1, rollback=0:
  - Latch pc.
  - Hit (valid && tag match): load instr_out, set instr_valid=1, go RESP. Hit latency is 1 cycle; instr_valid is high in the cycle after acceptance.
  - Miss: mem_req=1, mem_addr={pc[31:OFFSET_W],0}, counter=0, go FILL.
- FILL:
  - Each mem_rvalid writes mem_rdata into data[index][counter], then counter++.
  - On beat WORDS-1: write tag and set valid, drop mem_req.
  - If kill=0: set instr_valid=1 with the latched word (muxing the incoming beat if it is the requested word), go RESP.
  - If kill=1: clear kill, go COOL.
  - mem_rvalid outside FILL is ignored.
- RESP:
  - instr_valid and instr_out hold while fetch_stall=1.
  - First cycle with fetch_stall=0: the fetcher consumes the response. Next cycle instr_valid=0, go COOL.
- COOL: one cycle in which fetch_req is ignored (the fetcher's new pc lands this cycle), then go IDLE.
- rollback=1 (priority below rst and rdy):
  - IDLE: request not accepted.
  - RESP: instr_valid=0 next cycle, go COOL.
  - FILL: set kill. The fill runs to completion and the line is installed; no response is issued.
  - Rollback in the same cycle as the last beat: the line is installed, no response, go COOL.
- Rollback and fetch_stall=0 in the same RESP cycle: rollback wins; the response counts as not delivered.
- Reset mid-fill: mem_req drops on the next cycle; the partial line stays invalid. The memory controller must tolerate an abandoned request.
- Lines are never invalidated except by reset (no self-modifying code).

Decomposition:
- Shared header const.v holds `TRUE/`FALSE, `ZERO, `DATA_IDX_RANGE.
- New entries in const.v: `ICACHE_IDLE/FILL/RESP/COOL state encodings.
- One natural sub-module, icache_store: tag, valid and data arrays, with one combinational read port and one write port (word write plus a tag/valid commit strobe).
- FSM and memory interface stay in icache.

Test Plan:
1. Cold miss: rst, then fetch_req=1, pc=0x0000_0004.
   - mem_req=1, mem_addr=0x0.
   - Feed 4 beats 0x11,0x22,0x33,0x44 → instr_valid=1, instr_out=0x22 one cycle after the last beat; mem_req=0 the same cycle.
2. Hit after fill: after case 1, pc=0x0000_000C → instr_valid=1, instr_out=0x44 the next cycle; mem_req stays 0.
3. Stall hold: hit with fetch_stall=1 for 3 cycles → instr_valid stays 1 with a stable instr_out for all 3 cycles; it drops 1 cycle after fetch_stall=0; fetch_req is ignored during COOL.
4. Rollback during fill: miss on pc=0x100, rollback pulse after beat 1, finish 4 beats → no instr_valid. A later request to pc=0x104 hits in 1 cycle.
5. Conflict eviction: fill pc=0x0, then pc=0x400 (same index, INDEX_W=6, OFFSET_W=4) → second request misses. pc=0x0 then misses again (mem_addr=0x0).
6. rdy=0 mid-fill for 5 cycles with mem_rvalid=1 → counter, state and outputs unchanged. Resume and complete normally. Separately, rst mid-fill → mem_req=0 and that line is a miss afterwards.
